// File: rtl/ahb_bus_matrix_input_stage_if.sv
// Signal bundle between an upstream AHB master, the input stage and the
// matrix decoder. The slave modport is the input stage's view.
interface ahb_bus_matrix_input_stage_if;
    // Master-side address phase and handshake
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic        HMASTLOCKS;
    logic        HREADYS;
    logic        HREADYOUTS;
    logic [1:0]  HRESPS;

    // Decoder side
    logic        active_dec;
    logic        readyout_dec;
    logic [1:0]  resp_dec;
    logic        sel_in;
    logic [31:0] addr_in;
    logic [1:0]  trans_in;
    logic        write_in;
    logic [2:0]  size_in;
    logic [2:0]  burst_in;
    logic [3:0]  prot_in;
    logic        mastlock_in;

    modport slave (
        input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
               HMASTLOCKS, HREADYS, active_dec, readyout_dec, resp_dec,
        output HREADYOUTS, HRESPS, sel_in, addr_in, trans_in, write_in,
               size_in, burst_in, prot_in, mastlock_in
    );

    modport master (
        output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
               HMASTLOCKS, HREADYS, active_dec, readyout_dec, resp_dec,
        input  HREADYOUTS, HRESPS, sel_in, addr_in, trans_in, write_in,
               size_in, burst_in, prot_in, mastlock_in
    );
endinterface

// File: rtl/ahb_bus_matrix_input_stage.sv
// AHB bus-matrix input stage: forwards a master's address phase to the
// decoder, holding it in a register (and stalling the master) whenever the
// target output stage is not yet granted to this port.
module ahb_bus_matrix_input_stage (
    input  logic                          HCLK,
    input  logic                          HRESET,
    ahb_bus_matrix_input_stage_if.slave   s_bus
);

    typedef struct packed {
        logic        sel;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic        mastlock;
    } addr_phase_t;

    addr_phase_t w_live;
    addr_phase_t w_out;
    addr_phase_t r_hold;
    addr_phase_t w_hold_next;

    logic r_pend;
    logic r_dphase;
    logic w_pend_next;
    logic w_dphase_next;
    logic w_accept;
    logic w_hold;
    logic w_live_fwd;
    logic w_pend_fwd;

    assign w_live = {s_bus.HSELS, s_bus.HADDRS, s_bus.HTRANSS, s_bus.HWRITES,
                     s_bus.HSIZES, s_bus.HBURSTS, s_bus.HPROTS, s_bus.HMASTLOCKS};

    // State register: pend/dphase flags and the holding register
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_pend   <= 1'b0;
            r_dphase <= 1'b0;
            r_hold   <= '0;
        end else begin
            r_pend   <= w_pend_next;
            r_dphase <= w_dphase_next;
            r_hold   <= w_hold_next;
        end
    end

    // Next-state: hold, live forward, pending forward, data-phase completion.
    // A held transfer freezes the holding register until it is forwarded,
    // so a new accept is ignored while pend is set (the master is stalled then).
    always_comb begin
        w_accept      = s_bus.HREADYS & s_bus.HSELS & s_bus.HTRANSS[1];
        w_hold        = w_accept & ~s_bus.active_dec & ~r_pend;
        w_live_fwd    = w_accept &  s_bus.active_dec & ~r_pend;
        w_pend_fwd    = r_pend & s_bus.active_dec & s_bus.readyout_dec;
        w_pend_next   = r_pend;
        w_dphase_next = r_dphase;
        w_hold_next   = r_hold;

        if (w_hold) begin
            w_pend_next = 1'b1;
            w_hold_next = w_live;
        end
        if (w_pend_fwd) begin
            w_pend_next = 1'b0;
        end

        // A forward in the same cycle as completion keeps dphase set (back-to-back)
        if (w_live_fwd || w_pend_fwd) begin
            w_dphase_next = 1'b1;
        end else if (r_dphase && s_bus.readyout_dec) begin
            w_dphase_next = 1'b0;
        end
    end

    // Output path: held phase while pending, otherwise the live master bus
    always_comb begin
        w_out = r_pend ? r_hold : w_live;
        if (r_pend) begin
            w_out.sel = 1'b1;
        end

        s_bus.sel_in      = w_out.sel;
        s_bus.addr_in     = w_out.addr;
        s_bus.trans_in    = w_out.trans;
        s_bus.write_in    = w_out.write;
        s_bus.size_in     = w_out.size;
        s_bus.burst_in    = w_out.burst;
        s_bus.prot_in     = w_out.prot;
        s_bus.mastlock_in = w_out.mastlock;

        s_bus.HREADYOUTS  = 1'b1;
        s_bus.HRESPS      = 2'b00;
        if (r_pend) begin
            s_bus.HREADYOUTS = 1'b0;
        end else if (r_dphase) begin
            s_bus.HREADYOUTS = s_bus.readyout_dec;
            s_bus.HRESPS     = s_bus.resp_dec;
        end
    end

endmodule
